// File: rtl/c3lib_cfg_bus_loader.sv
// Serially loads a WIDTH-bit configuration word (LSB first) and commits it to cfg_out in one step.
// A load takes WIDTH+1 cycles after start; start while busy is dropped, and there is no backpressure.
module c3lib_cfg_bus_loader #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(4'b0011)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_sdata,
  input  logic             cfg_abort,
  input  logic             cfg_restore,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_loaded,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             loaded_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= RESET_VALUE;
      cfg_out    <= RESET_VALUE;
      cfg_loaded <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      cfg_out    <= out_nxt;
      cfg_loaded <= loaded_nxt;
      cfg_busy   <= busy_nxt;
      cfg_done   <= done_nxt;
      cfg_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    out_nxt    = cfg_out;
    loaded_nxt = cfg_loaded;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      IDLE: begin
        // Restore outranks start when both arrive together.
        if (cfg_restore) begin
          out_nxt    = RESET_VALUE;
          loaded_nxt = 1'b0;
        end else if (cfg_start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end

      SHIFT: begin
        if (cfg_abort) begin
          state_nxt  = IDLE;
          shadow_nxt = RESET_VALUE;
          err_nxt    = 1'b1;
        end else begin
          // Shift in from the top so the first bit lands in bit 0 after WIDTH samples.
          shadow_nxt            = shadow >> 1;
          shadow_nxt[WIDTH-1]   = cfg_sdata;
          cnt_nxt               = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nxt = APPLY;
          end
        end
      end

      APPLY: begin
        out_nxt    = shadow;
        loaded_nxt = 1'b1;
        done_nxt   = 1'b1;
        state_nxt  = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  done_err_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(cfg_done && cfg_err));

  cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CW'(WIDTH));

endmodule

// File: tb/tb_c3lib_cfg_bus_loader.sv
// Bench for c3lib_cfg_bus_loader: directed scenarios with literal expectations plus random traffic
// checked every cycle against a phase/queue model of the load protocol.
module tb_c3lib_cfg_bus_loader;

  localparam int           W  = 4;
  localparam logic [W-1:0] RV = 4'b0011;

  logic         clk;
  logic         rst_n;
  logic         cfg_start;
  logic         cfg_sdata;
  logic         cfg_abort;
  logic         cfg_restore;
  logic [W-1:0] cfg_out;
  logic         cfg_loaded;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  c3lib_cfg_bus_loader #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_sdata   (cfg_sdata),
    .cfg_abort   (cfg_abort),
    .cfg_restore (cfg_restore),
    .cfg_out     (cfg_out),
    .cfg_loaded  (cfg_loaded),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase counts edges since a start was accepted (0 = not loading);
  // bits collected so far live in a queue and are committed as a word.
  int           phase;
  bit           q[$];
  logic [W-1:0] m_out;
  logic         m_loaded, m_done, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      q.delete();
      m_out = RV;
      m_loaded = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (phase == 0) begin
        if (cfg_restore) begin
          m_out = RV;
          m_loaded = 1'b0;
        end else if (cfg_start) begin
          phase = 1;
          q.delete();
        end
      end else if (phase <= W) begin
        if (cfg_abort) begin
          phase = 0;
          m_err = 1'b1;
        end else begin
          q.push_back(cfg_sdata);
          phase++;
        end
      end else begin
        for (int i = 0; i < W; i++) m_out[i] = q[i];
        m_loaded = 1'b1;
        m_done = 1'b1;
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_out",    64'(cfg_out),    64'(m_out));
      chk("cmp_loaded", 64'(cfg_loaded), 64'(m_loaded));
      chk("cmp_busy",   64'(cfg_busy),   64'(phase != 0));
      chk("cmp_done",   64'(cfg_done),   64'(m_done));
      chk("cmp_err",    64'(cfg_err),    64'(m_err));
    end
  end

  task automatic cyc(input logic s, input logic d, input logic a, input logic r);
    cfg_start = s;
    cfg_sdata = d;
    cfg_abort = a;
    cfg_restore = r;
    @(negedge clk);
  endtask

  // Returns at the negedge after the commit edge, i.e. in the cfg_done cycle.
  task automatic do_load(input logic [W-1:0] bits, input logic hold_start,
                         input logic abort_apply, output int bc);
    bc = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bc += int'(cfg_busy);
    for (int i = 0; i < W; i++) begin
      cyc(hold_start, bits[i], 1'b0, 1'b0);
      bc += int'(cfg_busy);
    end
    cyc(1'b0, 1'b0, abort_apply, 1'b0);
    bc += int'(cfg_busy);
  endtask

  initial begin
    int bc;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_sdata = 1'b0;
    cfg_abort = 1'b0;
    cfg_restore = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_out",    64'(cfg_out),    64'(4'b0011));
    chk("rst_loaded", 64'(cfg_loaded), 64'd0);
    chk("rst_busy",   64'(cfg_busy),   64'd0);
    chk("rst_done",   64'(cfg_done),   64'd0);
    chk("rst_err",    64'(cfg_err),    64'd0);
    rst_n = 1'b1;

    // Normal load 1,0,1,1 straight out of reset.
    do_load(4'b1101, 1'b0, 1'b0, bc);
    chk("load_busy_cycles", 64'(bc),         64'd5);
    chk("load_done",        64'(cfg_done),   64'd1);
    chk("load_out",         64'(cfg_out),    64'(4'b1101));
    chk("load_loaded",      64'(cfg_loaded), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_one_cycle",   64'(cfg_done),   64'd0);

    // Abort after two bits keeps the committed word.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_err",    64'(cfg_err),  64'd1);
    chk("abort_out",    64'(cfg_out),  64'(4'b1101));
    chk("abort_done",   64'(cfg_done), 64'd0);
    chk("abort_busy",   64'(cfg_busy), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_err_one_cycle", 64'(cfg_err), 64'd0);

    // Start held through SHIFT and abort during APPLY change nothing.
    do_load(4'b0110, 1'b1, 1'b1, bc);
    chk("hold_busy_cycles", 64'(bc),       64'd5);
    chk("hold_done",        64'(cfg_done), 64'd1);
    chk("hold_out",         64'(cfg_out),  64'(4'b0110));
    // Back-to-back load started in the cfg_done cycle, bits 0,0,0,1.
    do_load(4'b1000, 1'b0, 1'b0, bc);
    chk("b2b_busy_cycles",  64'(bc),       64'd5);
    chk("b2b_done",         64'(cfg_done), 64'd1);
    chk("b2b_out",          64'(cfg_out),  64'(4'b1000));

    // Restore beats start in IDLE.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restore_out",    64'(cfg_out),    64'(4'b0011));
    chk("restore_loaded", 64'(cfg_loaded), 64'd0);
    chk("restore_busy",   64'(cfg_busy),   64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("restore_busy2",  64'(cfg_busy),   64'd0);

    // Asynchronous reset between edges in the middle of SHIFT.
    do_load(4'b1101, 1'b0, 1'b0, bc);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out",    64'(cfg_out),    64'(4'b0011));
    chk("arst_loaded", 64'(cfg_loaded), 64'd0);
    chk("arst_busy",   64'(cfg_busy),   64'd0);
    chk("arst_done",   64'(cfg_done),   64'd0);
    chk("arst_err",    64'(cfg_err),    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
